// File: rtl/selfadd_heap_drain_pkg.sv
// Shared types and defaults for the self-add heap drain path.
// Defaults track the 2x16b accumulator heap geometry.
package selfadd_heap_drain_pkg;

    localparam int DATA_W         = 16;
    localparam int PAIR_W         = 2 * DATA_W;
    localparam int DEF_NUM_UNITS  = 32;
    localparam int DEF_IDX_W      = 5;
    localparam int DEF_SETTLE_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/selfadd_heap_drain_if.sv
// Drained-word stream toward the result collector.
// Master presents {b,a} words; slave accepts with out_rdy.
interface selfadd_heap_drain_if
    import selfadd_heap_drain_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) ();

    logic [PAIR_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_v;
    logic              out_rdy;
    logic              out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_v,
        output out_last,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_v,
        input  out_last,
        output out_rdy
    );

endinterface

// File: rtl/selfadd_heap_drain_settle.sv
// Quiet-cycle counter: pulses settled once the heap has seen
// SETTLE_CYC consecutive cycles with no write or add activity.
module selfadd_drain_settle
    import selfadd_heap_drain_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic act,
    output logic settled
);

    localparam int CW = $clog2(SETTLE_CYC) + 1;

    logic [CW-1:0] cnt;

    assign settled = run & ~act
                   & (cnt == CW'(SETTLE_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start || !run || act) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/selfadd_heap_drain.sv
// Drains the 2x16b self-add heap slot by slot, then holds the
// heap's usr_rst so the next accumulation restarts from zero.
module selfadd_heap_drain
    import selfadd_heap_drain_pkg::*;
#(
    parameter int NUM_UNITS  = DEF_NUM_UNITS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drain_start,
    input  logic                 up_data_v,
    input  logic                 acc_v_in,
    output logic [IDX_W-1:0]     rd_idx,
    input  logic [DATA_W-1:0]    rd_data_a,
    input  logic [DATA_W-1:0]    rd_data_b,
    selfadd_heap_drain_if.master out_if,
    output logic                 usr_rst_o,
    output logic                 busy,
    output logic                 done,
    output logic                 ovr_err
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             settled;
    logic             idx_last;
    logic             reading;

    assign rd_idx   = idx;
    assign idx_last = (idx == IDX_W'(NUM_UNITS - 1));
    assign reading  = (state == ST_FETCH)
                    | (state == ST_SEND);

    selfadd_drain_settle #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .start   ((state == ST_IDLE) && drain_start),
        .run     (state == ST_SETTLE),
        .act     (up_data_v | acc_v_in),
        .settled (settled)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            out_if.out_data <= '0;
            out_if.out_idx  <= '0;
            out_if.out_v    <= 1'b0;
            out_if.out_last <= 1'b0;
            usr_rst_o       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            ovr_err         <= 1'b0;
        end else begin
            done <= 1'b0;
            // First add after a drain sees A=0, then release.
            if (usr_rst_o && up_data_v) begin
                usr_rst_o <= 1'b0;
            end
            if (reading && (up_data_v || acc_v_in)) begin
                ovr_err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (drain_start) begin
                        state   <= ST_SETTLE;
                        busy    <= 1'b1;
                        ovr_err <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settled) begin
                        state <= ST_FETCH;
                        idx   <= '0;
                    end
                end
                ST_FETCH: begin
                    out_if.out_data <= {rd_data_b, rd_data_a};
                    out_if.out_idx  <= idx;
                    out_if.out_last <= idx_last;
                    out_if.out_v    <= 1'b1;
                    state           <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_if.out_rdy) begin
                        out_if.out_v <= 1'b0;
                        if (out_if.out_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    usr_rst_o <= 1'b1;
                    idx       <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selfadd_heap_drain.sv
// Scoreboard bench for selfadd_heap_drain with a 4-slot heap model.
// Directed drains: latency, settle restart, backpressure, usr_rst, ovr_err, reset.
module tb_selfadd_heap_drain;

    localparam int NU = 4;
    localparam int IW = 2;

    typedef struct {
        logic [31:0]   d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          drain_start;
    logic          up_data_v;
    logic          acc_v_in;
    logic [IW-1:0] rd_idx;
    logic [15:0]   rd_a;
    logic [15:0]   rd_b;
    logic          usr_rst_o;
    logic          busy;
    logic          done;
    logic          ovr_err;

    logic [IW-1:0] up_idx;
    logic [15:0]   up_a;
    logic [15:0]   up_b;
    logic          load;
    logic [31:0]   slot [NU];

    int   cyc;
    int   t0;
    int   passed;
    int   total;
    int   stalls;
    int   last_hs_cyc;
    exp_t q [$];

    selfadd_heap_drain_if #(.IDX_W(IW)) bus ();

    selfadd_heap_drain #(
        .NUM_UNITS  (NU),
        .IDX_W      (IW),
        .SETTLE_CYC (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .drain_start (drain_start),
        .up_data_v   (up_data_v),
        .acc_v_in    (acc_v_in),
        .rd_idx      (rd_idx),
        .rd_data_a   (rd_a),
        .rd_data_b   (rd_b),
        .out_if      (bus),
        .usr_rst_o   (usr_rst_o),
        .busy        (busy),
        .done        (done),
        .ovr_err     (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Heap model: adds into a slot, or replaces it while usr_rst is held.
    assign rd_a = slot[rd_idx][15:0];
    assign rd_b = slot[rd_idx][31:16];

    always @(posedge clk) begin
        if (load) begin
            slot[0] <= 32'h0001_0010;
            slot[1] <= 32'h0002_0020;
            slot[2] <= 32'h0003_0030;
            slot[3] <= 32'hFFFF_FFFF;
        end else if (up_data_v) begin
            if (usr_rst_o)
                slot[up_idx] <= {up_b, up_a};
            else
                slot[up_idx] <= {slot[up_idx][31:16] + up_b,
                                 slot[up_idx][15:0] + up_a};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard on every handshake.
    logic        stall_prev;
    logic [35:0] snap;

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_stable",
                    {bus.out_v, bus.out_last, bus.out_idx, bus.out_data}, snap);
            if (bus.out_v && bus.out_rdy) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_word", bus.out_data, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", bus.out_data, e.d);
                    chk("sb_idx", bus.out_idx, e.i);
                    chk("sb_last", bus.out_last, e.l);
                end
                if (bus.out_last) last_hs_cyc = cyc;
                stall_prev = 1'b0;
            end else if (bus.out_v) begin
                stall_prev = 1'b1;
                snap = {bus.out_v, bus.out_last, bus.out_idx, bus.out_data};
                stalls++;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic push4(input logic [31:0] w0, w1, w2, w3);
        q.push_back('{d: w0, i: 2'd0, l: 1'b0});
        q.push_back('{d: w1, i: 2'd1, l: 1'b0});
        q.push_back('{d: w2, i: 2'd2, l: 1'b0});
        q.push_back('{d: w3, i: 2'd3, l: 1'b1});
    endtask

    task automatic kick();
        drain_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        drain_start = 1'b0;
    endtask

    task automatic drain(input int hold_idx, input int hold_n,
                         input bit acc_mode, input bit up_mode,
                         output int first, output int dn);
        int held;
        bit up_done;
        int rel;
        held = 0;
        up_done = 0;
        first = -1;
        dn = -1;
        kick();
        for (int n = 0; n < 200; n++) begin
            rel = cyc - t0;
            acc_v_in = acc_mode && (rel == 2 || rel == 4);
            if (up_mode && bus.out_v && !up_done) begin
                up_data_v = 1'b1;
                up_done = 1;
            end else begin
                up_data_v = 1'b0;
            end
            if (bus.out_v && first < 0) first = rel;
            if (bus.out_v && int'(bus.out_idx) == hold_idx && held < hold_n) begin
                bus.out_rdy = 1'b0;
                held++;
            end else begin
                bus.out_rdy = 1'b1;
            end
            if (done) begin
                dn = rel;
                break;
            end
            @(negedge clk);
        end
        acc_v_in = 1'b0;
        up_data_v = 1'b0;
        chk("drain_done_seen", dn >= 0, 1);
        chk("sb_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int  f;
        int  d;
        bit  saw;
        bit  hit;
        rst = 1'b0;
        load = 1'b1;
        drain_start = 1'b0;
        up_data_v = 1'b0;
        acc_v_in = 1'b0;
        up_idx = '0;
        up_a = '0;
        up_b = '0;
        bus.out_rdy = 1'b1;
        cyc = 0;
        passed = 0;
        total = 0;
        stalls = 0;
        last_hs_cyc = 0;
        stall_prev = 1'b0;
        snap = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_v", bus.out_v, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_usr_ovr", {usr_rst_o, ovr_err}, 0);
        chk("rst_rd_idx", rd_idx, 0);
        rst = 1'b1;
        load = 1'b0;
        @(negedge clk);

        // Quiet heap, full throughput.
        push4(32'h0001_0010, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(-1, 0, 0, 0, f, d);
        chk("s1_first_latency", f, 5);
        chk("s1_done_cycle", d, 12);
        chk("s1_done_after_last_hs", cyc - last_hs_cyc, 1);
        @(negedge clk);
        chk("s1_done_one_cycle", done, 0);
        chk("s1_usr_rst_set", usr_rst_o, 1);
        chk("s1_busy_clear", busy, 0);

        // First add after drain replaces the slot.
        up_data_v = 1'b1;
        up_idx = 2'd0;
        up_b = 16'd5;
        up_a = 16'd7;
        chk("s4_usr_rst_on_add", usr_rst_o, 1);
        @(negedge clk);
        up_data_v = 1'b0;
        chk("s4_usr_rst_dropped", usr_rst_o, 0);
        @(negedge clk);
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(-1, 0, 0, 0, f, d);
        chk("s4_first_latency", f, 5);

        // Add-pipeline activity restarts the settle window.
        @(negedge clk);
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(-1, 0, 1, 0, f, d);
        chk("s2_first_latency", f, 9);
        chk("s2_done_cycle", d, 16);
        chk("s2_no_ovr", ovr_err, 0);

        // Backpressure on idx 1.
        @(negedge clk);
        stalls = 0;
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(1, 5, 0, 0, f, d);
        chk("s3_stall_cycles", stalls, 5);
        chk("s3_first_latency", f, 5);
        chk("s3_done_cycle", d, 17);

        // Upstream write during SEND flags ovr_err.
        @(negedge clk);
        chk("s5_ovr_before", ovr_err, 0);
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(-1, 0, 0, 1, f, d);
        chk("s5_done_cycle", d, 12);
        chk("s5_ovr_sticky", ovr_err, 1);
        @(negedge clk);
        chk("s5_ovr_still", ovr_err, 1);

        // Reset in the middle of SEND on idx 2.
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        kick();
        chk("s6_ovr_cleared", ovr_err, 0);
        hit = 0;
        for (int n = 0; n < 100; n++) begin
            if (bus.out_v && bus.out_idx == 2'd2) begin
                bus.out_rdy = 1'b0;
                hit = 1;
                break;
            end
            bus.out_rdy = 1'b1;
            @(negedge clk);
        end
        chk("s6_reached_idx2", hit, 1);
        chk("s6_usr_rst_before", usr_rst_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_async_out_v", bus.out_v, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_usr_rst", usr_rst_o, 0);
        saw = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("s6_no_done", saw, 0);
        q.delete();
        bus.out_rdy = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        push4(32'h0005_0007, 32'h0002_0020, 32'h0003_0030, 32'hFFFF_FFFF);
        drain(-1, 0, 0, 0, f, d);
        chk("s6_restart_latency", f, 5);
        chk("s6_restart_done", d, 12);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
